wb_axi_drain_ctrl: RTL and testbench

- Sequencer between the write buffer's head entry and the AXI4 write channel.
- Takes one 128-bit line per drain and issues a single-beat-address, 4-beat INCR burst (AW, then W, then B).
- Returns a one-cycle pop pulse to the write buffer (its AXI_valid_i input).
- Schedules drains against pending read refills: defers starts while a refill is pending, bounded by a starvation limit.

---
 rtl/wb_axi_drain_ctrl.sv | 165 ++++++++++++++++
 tb/tb_wb_axi_drain_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_axi_drain_ctrl.sv
// rtl/wb_axi_drain_ctrl.sv - drains the write-buffer head line as one 4-beat AXI4 INCR write burst
// Optional feature macro: WB_DRAIN_ERR_EN (sticky bresp error flag and first error address)
module wb_axi_drain_ctrl #(
    parameter int          ADDR_W    = 32,
    parameter int          LINE_W    = 128,
    parameter int          BEAT_W    = 32,
    parameter logic [3:0]  AXI_ID    = 4'd1,
    parameter int          MAX_DEFER = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_wen_i,
    input  logic [ADDR_W-1:0]     wb_waddr_i,
    input  logic [LINE_W-1:0]     wb_wdata_i,
    input  logic                  wb_full_i,
    output logic                  wb_done_o,
    input  logic                  rd_req_i,
    output logic                  busy_o,
    output logic [3:0]            awid_o,
    output logic [ADDR_W-1:0]     awaddr_o,
    output logic [7:0]            awlen_o,
    output logic [2:0]            awsize_o,
    output logic [1:0]            awburst_o,
    output logic                  awvalid_o,
    input  logic                  awready_i,
    output logic [BEAT_W-1:0]     wdata_o,
    output logic [BEAT_W/8-1:0]   wstrb_o,
    output logic                  wlast_o,
    output logic                  wvalid_o,
    input  logic                  wready_i,
    input  logic [1:0]            bresp_i,
    input  logic                  bvalid_i,
    output logic                  bready_o
`ifdef WB_DRAIN_ERR_EN
    ,
    output logic                  err_o,
    output logic [ADDR_W-1:0]     err_addr_o
`endif
);

    localparam int BEATS   = LINE_W / BEAT_W;
    localparam int BEAT_CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int DEFER_W = $clog2(MAX_DEFER + 1);
    localparam logic [BEAT_CW-1:0] LAST_BEAT = BEAT_CW'(BEATS - 1);
    localparam logic [DEFER_W-1:0] DEFER_MAX = DEFER_W'(MAX_DEFER);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [ADDR_W-1:0]    r_addr;
    logic [LINE_W-1:0]    r_line;
    logic [BEAT_CW-1:0]   r_beat;
    logic [DEFER_W-1:0]   r_defer;
    logic                 w_start;
    logic                 w_last_beat;

    // Refills win arbitration unless the buffer is full or the drain has waited too long.
    assign w_start     = wb_wen_i && (!rd_req_i || wb_full_i || (r_defer == DEFER_MAX));
    assign w_last_beat = (r_beat == LAST_BEAT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_start)                   w_next = S_AW;
            S_AW:   if (awready_i)                 w_next = S_W;
            S_W:    if (wready_i && w_last_beat)   w_next = S_B;
            S_B:    if (bvalid_i)                  w_next = S_DONE;
            S_DONE:                                w_next = S_IDLE;
            default:                               w_next = S_IDLE;
        endcase
    end

    always_comb begin
        awvalid_o = 1'b0;
        wvalid_o  = 1'b0;
        wlast_o   = 1'b0;
        bready_o  = 1'b0;
        wb_done_o = 1'b0;
        busy_o    = (r_state != S_IDLE);
        case (r_state)
            S_AW:   awvalid_o = 1'b1;
            S_W: begin
                wvalid_o = 1'b1;
                wlast_o  = w_last_beat;
            end
            S_B:    bready_o  = 1'b1;
            S_DONE: wb_done_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_line  <= '0;
            r_beat  <= '0;
            r_defer <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_addr  <= wb_waddr_i;
                        r_line  <= wb_wdata_i;
                        r_defer <= '0;
                    end else if (wb_wen_i) begin
                        if (r_defer != DEFER_MAX) begin
                            r_defer <= r_defer + 1'b1;
                        end
                    end else begin
                        r_defer <= '0;
                    end
                end
                S_AW: if (awready_i) r_beat <= '0;
                S_W:  if (wready_i)  r_beat <= r_beat + 1'b1;
                default: ;
            endcase
        end
    end

    assign awid_o    = AXI_ID;
    assign awaddr_o  = r_addr;
    assign awlen_o   = 8'(BEATS - 1);
    assign awsize_o  = 3'b010;
    assign awburst_o = 2'b01;
    assign wdata_o   = r_line[int'(r_beat) * BEAT_W +: BEAT_W];
    assign wstrb_o   = '1;

`ifdef WB_DRAIN_ERR_EN
    logic                 r_err;
    logic [ADDR_W-1:0]    r_err_addr;

    // Only the first failing burst is recorded; the entry is still popped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end else if ((r_state == S_B) && bvalid_i && (bresp_i != 2'b00) && !r_err) begin
            r_err      <= 1'b1;
            r_err_addr <= r_addr;
        end
    end

    assign err_o      = r_err;
    assign err_addr_o = r_err_addr;
`else
    logic w_unused_bresp;
    assign w_unused_bresp = ^bresp_i;
`endif

endmodule

// File: tb/tb_wb_axi_drain_ctrl.sv
// tb/tb_wb_axi_drain_ctrl.sv - randomized self-checking bench for wb_axi_drain_ctrl
module tb_wb_axi_drain_ctrl;

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_wen_i;
    logic [31:0]   wb_waddr_i;
    logic [127:0]  wb_wdata_i;
    logic          wb_full_i;
    logic          wb_done_o;
    logic          rd_req_i;
    logic          busy_o;
    logic [3:0]    awid_o;
    logic [31:0]   awaddr_o;
    logic [7:0]    awlen_o;
    logic [2:0]    awsize_o;
    logic [1:0]    awburst_o;
    logic          awvalid_o;
    logic          awready_i;
    logic [31:0]   wdata_o;
    logic [3:0]    wstrb_o;
    logic          wlast_o;
    logic          wvalid_o;
    logic          wready_i;
    logic [1:0]    bresp_i;
    logic          bvalid_i;
    logic          bready_o;
`ifdef WB_DRAIN_ERR_EN
    logic          err_o;
    logic [31:0]   err_addr_o;
`endif

    wb_axi_drain_ctrl dut (
        .clk(clk), .rst(rst),
        .wb_wen_i(wb_wen_i), .wb_waddr_i(wb_waddr_i), .wb_wdata_i(wb_wdata_i),
        .wb_full_i(wb_full_i), .wb_done_o(wb_done_o), .rd_req_i(rd_req_i), .busy_o(busy_o),
        .awid_o(awid_o), .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o),
        .awburst_o(awburst_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o),
        .wready_i(wready_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o)
`ifdef WB_DRAIN_ERR_EN
        , .err_o(err_o), .err_addr_o(err_addr_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  addr;
        logic [127:0] data;
    } ent_t;

    ent_t          wb_q[$];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            rdy_mode = 0;
    bit            rd_manual = 1'b1;
    bit            mutate = 1'b0;
    logic [1:0]    bresp_val = 2'b00;
    int            done_cnt = 0;
    int            aw_times[$];
    int            done_times[$];
    logic [31:0]   beats[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_ent(input logic [31:0] a, input logic [127:0] d);
        ent_t e;
        e.addr = a;
        e.data = d;
        wb_q.push_back(e);
    endtask

    task automatic push_rand();
        push_ent($urandom & 32'hFFFF_FFF0, {$urandom, $urandom, $urandom, $urandom});
    endtask

    task automatic wait_drained(input int limit);
        int n;
        n = 0;
        while ((wb_q.size() != 0 || busy_o) && n < limit) begin
            @(posedge clk); #3;
            n++;
        end
        check("drain_timeout", n < limit, 1'b1);
    endtask

    // Write-buffer side and AXI slave side stimulus, driven just after each rising edge.
    initial begin : driver
        int aw_cnt, b_cnt;
        bit tog;
        aw_cnt = 0; b_cnt = 0; tog = 1'b0;
        wb_wen_i = 0; wb_waddr_i = 0; wb_wdata_i = 0; wb_full_i = 0; rd_req_i = 0;
        awready_i = 0; wready_i = 0; bvalid_i = 0; bresp_i = 0;
        forever begin
            @(posedge clk); #1;
            if (wb_q.size() == 0) begin
                wb_wen_i = 1'b0;
            end else if (!busy_o) begin
                wb_wen_i   = 1'b1;
                wb_waddr_i = wb_q[0].addr;
                wb_wdata_i = wb_q[0].data;
            end else begin
                wb_wen_i = !wb_done_o;
                if (mutate) begin
                    wb_waddr_i = $urandom;
                    wb_wdata_i = {$urandom, $urandom, $urandom, $urandom};
                end
            end
            if (!rd_manual) begin
                rd_req_i  = ($urandom_range(0, 2) != 0);
                wb_full_i = ($urandom_range(0, 9) == 0);
            end
            bresp_i = bresp_val;
            case (rdy_mode)
                0: begin
                    awready_i = 1'b1;
                    wready_i  = 1'b1;
                    bvalid_i  = bready_o;
                end
                1: begin
                    awready_i = ($urandom_range(0, 2) != 0);
                    wready_i  = ($urandom_range(0, 2) != 0);
                    bvalid_i  = bready_o && ($urandom_range(0, 2) != 0);
                end
                default: begin
                    awready_i = awvalid_o && (aw_cnt == 3);
                    aw_cnt    = awvalid_o ? aw_cnt + 1 : 0;
                    tog       = ~tog;
                    wready_i  = tog;
                    bvalid_i  = bready_o && (b_cnt == 5);
                    b_cnt     = bready_o ? b_cnt + 1 : 0;
                end
            endcase
        end
    end

    // Protocol monitor and scoreboard, sampled on the falling edge.
    initial begin : monitor
        bit          pred_valid, pred_start, aw_seen, b_seen;
        bit          p_aw_stall, p_w_stall, p_w_cont, p_done;
        int          mdef;
        logic [31:0] aw_got, p_awaddr, p_wdata, exp_beat;
        ent_t        e;
        pred_valid = 0; pred_start = 0; aw_seen = 0; b_seen = 0; mdef = 0;
        p_aw_stall = 0; p_w_stall = 0; p_w_cont = 0; p_done = 0;
        aw_got = 0; p_awaddr = 0; p_wdata = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pred_valid = 0; mdef = 0; aw_seen = 0; b_seen = 0; beats.delete();
                p_aw_stall = 0; p_w_stall = 0; p_w_cont = 0; p_done = 0;
            end else begin
                if (pred_valid) check("start_pred", awvalid_o, pred_start);
                if (!busy_o) begin
                    pred_valid = 1;
                    if (wb_wen_i) begin
                        pred_start = !rd_req_i || wb_full_i || (mdef == 15);
                        mdef = pred_start ? 0 : ((mdef < 15) ? mdef + 1 : 15);
                    end else begin
                        pred_start = 0;
                        mdef = 0;
                    end
                end else begin
                    pred_valid = 0;
                end
                if (p_aw_stall) begin
                    check("aw_hold", awvalid_o, 1'b1);
                    check("awaddr_hold", awaddr_o, p_awaddr);
                end
                if (p_w_stall) begin
                    check("w_hold", wvalid_o, 1'b1);
                    check("wdata_hold", wdata_o, p_wdata);
                end
                if (p_w_cont) check("w_gap", wvalid_o, 1'b1);
                if (p_done) check("done_len", wb_done_o, 1'b0);
                if (awvalid_o && awready_i) begin
                    check("aw_dup", aw_seen, 1'b0);
                    check("aw_attr", {awid_o, awlen_o, awsize_o, awburst_o}, {4'd1, 8'd3, 3'b010, 2'b01});
                    aw_seen = 1;
                    aw_got = awaddr_o;
                    aw_times.push_back(cyc);
                end
                if (wvalid_o && wready_i) begin
                    check("w_after_aw", aw_seen, 1'b1);
                    check("wstrb", wstrb_o, 4'hf);
                    check("wlast", wlast_o, beats.size() == 3);
                    beats.push_back(wdata_o);
                end
                if (bready_o && bvalid_i) b_seen = 1;
                if (wb_done_o) begin
                    done_cnt++;
                    done_times.push_back(cyc);
                    check("done_has_entry", wb_q.size() > 0, 1'b1);
                    if (wb_q.size() > 0) begin
                        e = wb_q.pop_front();
                        check("awaddr", aw_got, e.addr);
                        check("nbeats", beats.size(), 4);
                        for (int i = 0; i < beats.size() && i < 4; i++) begin
                            exp_beat = e.data[i*32 +: 32];
                            check("wdata", beats[i], exp_beat);
                        end
                        check("b_before_done", b_seen, 1'b1);
                    end
                    aw_seen = 0; b_seen = 0; beats.delete();
                end
                p_aw_stall = awvalid_o && !awready_i;
                p_awaddr   = awaddr_o;
                p_w_stall  = wvalid_o && !wready_i;
                p_wdata    = wdata_o;
                p_w_cont   = wvalid_o && wready_i && !wlast_o;
                p_done     = wb_done_o;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n, t_aw, d0, na, nd;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        check("rst_outs", {busy_o, awvalid_o, wvalid_o, wlast_o, bready_o, wb_done_o}, 6'b0);
        check("rst_awaddr", awaddr_o, 32'h0);
        check("rst_wdata", wdata_o, 32'h0);
`ifdef WB_DRAIN_ERR_EN
        check("rst_err", {err_o, err_addr_o}, 33'h0);
`endif
        rst = 1'b0;

        // Single drain, all readies high.
        push_ent(32'h0000_1230, 128'h44444444_33333333_22222222_11111111);
        n = 0;
        while (!awvalid_o && n < 20) begin @(posedge clk); #3; n++; end
        check("aw_seen", awvalid_o, 1'b1);
        check("aw_addr_single", awaddr_o, 32'h0000_1230);
        t_aw = cyc;
        n = 0;
        while (!wb_done_o && n < 20) begin @(posedge clk); #3; n++; end
        check("done_latency", cyc - t_aw, 6);
        wait_drained(20);

        // Scripted backpressure.
        rdy_mode = 2;
        d0 = done_cnt;
        push_rand();
        wait_drained(100);
        check("bp_done_cnt", done_cnt - d0, 1);
        rdy_mode = 0;

        // Deferral to the starvation limit.
        rd_req_i = 1'b1; wb_full_i = 1'b0;
        push_rand();
        n = 0;
        for (int k = 0; k < 40 && !awvalid_o; k++) begin
            @(posedge clk); #3;
            if (!awvalid_o && wb_wen_i && !busy_o) n++;
        end
        check("defer_cycles", n, 16);
        wait_drained(40);

        // Full raised during deferral starts immediately.
        push_rand();
        n = 0;
        for (int k = 0; k < 40 && !awvalid_o; k++) begin
            @(posedge clk); #3;
            if (!awvalid_o && wb_wen_i && !busy_o) begin
                n++;
                if (n == 5) wb_full_i = 1'b1;
            end
        end
        check("full_cycles", n, 5);
        wait_drained(40);
        rd_req_i = 1'b0; wb_full_i = 1'b0;

        // Reset during the second W beat.
        push_rand();
        n = 0;
        while (!(wvalid_o && beats.size() == 1) && n < 30) begin @(posedge clk); #3; n++; end
        check("reached_beat2", wvalid_o, 1'b1);
        d0 = done_cnt;
        rst = 1'b1;
        #1;
        check("rst_mid", {wvalid_o, busy_o, wb_done_o, awvalid_o, bready_o}, 5'b0);
        wb_q.delete();
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #3;
        check("rst_no_done", done_cnt - d0, 0);
        check("rst_idle", busy_o, 1'b0);

        // Back-to-back drains.
        na = aw_times.size();
        nd = done_times.size();
        push_rand();
        push_rand();
        wait_drained(60);
        check("b2b_aw_cnt", aw_times.size() - na, 2);
        if (aw_times.size() >= na + 2) begin
            check("b2b_aw_gap", aw_times[na+1] - aw_times[na], 8);
            check("b2b_done_gap", (done_times[nd+1] - done_times[nd]) >= 8, 1'b1);
        end

        // Randomized traffic, arbitration and snapshot under mutation.
        rdy_mode = 1;
        rd_manual = 1'b0;
        mutate = 1'b1;
        d0 = done_cnt;
        for (int k = 0; k < 25; k++) push_rand();
        wait_drained(5000);
        check("rand_done_cnt", done_cnt - d0, 25);
        rdy_mode = 0;
        rd_manual = 1'b1;
        mutate = 1'b0;
        @(posedge clk); #3;
        rd_req_i = 1'b0; wb_full_i = 1'b0;

`ifdef WB_DRAIN_ERR_EN
        bresp_val = 2'b10;
        push_ent(32'h0000_ABC0, {4{32'hDEAD_BEEF}});
        wait_drained(40);
        bresp_val = 2'b00;
        push_ent(32'h0000_1110, {4{32'h1234_5678}});
        wait_drained(40);
        check("err_flag", err_o, 1'b1);
        check("err_addr", err_addr_o, 32'h0000_ABC0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
